// File: rtl/time_digit_seq.sv
// Time-field to display-digit encoder: converts NF binary fields one bit per cycle
// with a shift-and-add-3 engine, then applies AP/PM, blanking and overflow rules.
module time_digit_seq #(
  parameter int unsigned NF = 3,
  parameter int unsigned FW = 7,
  parameter int unsigned ND = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NF*FW-1:0]   fields,
  input  logic               ap_mode,
  input  logic               lz_mode,
  output logic [NF*ND*4-1:0] digits,
  output logic [NF-1:0]      ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BW    = ND * 4;
  localparam int unsigned DW    = BW + FW;
  localparam int unsigned CW    = (FW > 1) ? $clog2(FW) : 1;
  localparam int unsigned XW    = $clog2(NF);
  localparam int unsigned LIMIT = pow10(ND);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;
  logic [NF*FW-1:0] r_fld;
  logic [NF-1:0]    r_ovf;
  logic             r_pm;
  logic             r_inv;
  logic             r_ap;
  logic             r_lz;
  logic [DW-1:0]    r_dab;
  logic [CW-1:0]    r_bit;
  logic [XW-1:0]    r_fidx;
  logic [NF*BW-1:0] r_work;

  logic [NF*FW-1:0]   w_cap_fld;
  logic [NF-1:0]      w_cap_ovf;
  logic               w_cap_pm;
  logic               w_cap_inv;
  logic [FW-1:0]      w_val;
  logic [DW-1:0]      w_dab_adj;
  logic [DW-1:0]      w_dab_nxt;
  logic [DW-1:0]      w_dab_load;
  logic [XW-1:0]      w_fidx_nxt;
  logic               w_last_bit;
  logic               w_last_fld;
  logic [NF*BW-1:0]   w_src_work;
  logic [NF-1:0]      w_src_ovf;
  logic [NF*ND*4-1:0] w_digits;
  logic [NF-1:0]      w_ovf;
  logic               w_blank;
  logic [3:0]         w_nib;

  assign in_ready = r_in_ready;

  // Capture-time hour adjustment (12-hour mode) and per-field range check
  always_comb begin
    w_cap_fld = '0;
    w_cap_ovf = '0;
    w_val     = '0;
    w_cap_inv = &fields[(NF-1)*FW +: FW];
    w_cap_pm  = 32'(fields[(NF-1)*FW +: FW]) >= 32'd12;
    for (int i = 0; i < int'(NF); i++) begin
      w_val = fields[(int'(NF)-1-i)*int'(FW) +: FW];
      if (i == 0 && ap_mode) begin
        if (w_val == '0) w_val = FW'(12);
        else if (32'(w_val) >= 32'd13) w_val = w_val - FW'(12);
      end
      w_cap_fld[i*int'(FW) +: FW] = w_val;
      w_cap_ovf[i] = 32'(w_val) >= LIMIT;
    end
  end

  // One dabble step: correct BCD nibbles >= 5, then shift left
  always_comb begin
    w_dab_adj = r_dab;
    for (int k = 0; k < int'(ND); k++) begin
      if (r_dab[int'(FW)+4*k +: 4] >= 4'd5)
        w_dab_adj[int'(FW)+4*k +: 4] = r_dab[int'(FW)+4*k +: 4] + 4'd3;
    end
  end

  assign w_dab_nxt  = {w_dab_adj[DW-2:0], 1'b0};
  assign w_last_bit = (r_bit == CW'(FW-1));
  assign w_last_fld = (r_fidx == XW'(NF-1));
  assign w_fidx_nxt = r_fidx + XW'(1);
  assign w_dab_load = {BW'(0), r_fld[w_fidx_nxt*FW +: FW]};

  // In 12-hour mode every displayed field moves one slot right of its index
  assign w_src_work = r_ap ? (r_work << BW) : r_work;
  assign w_src_ovf  = r_ap ? (r_ovf << 1) : r_ovf;

  always_comb begin
    w_digits = '1;
    w_ovf    = '0;
    w_blank  = 1'b0;
    w_nib    = '0;
    if (!r_inv) begin
      w_ovf = r_ovf;
      for (int s = 0; s < int'(NF); s++) begin
        w_blank = r_lz && !r_ap && (s < int'(NF) - 1);
        for (int d = 0; d < int'(ND); d++) begin
          if (r_ap && s == 0) begin
            w_nib = (d == 0) ? (r_pm ? 4'd12 : 4'd13) : 4'd14;
          end else if (w_src_ovf[s]) begin
            w_nib = 4'd15;
          end else begin
            w_nib = w_src_work[s*int'(BW) + (int'(ND)-1-d)*4 +: 4];
            if (w_blank && d < int'(ND) - 1 && w_nib == 4'd0) w_nib = 4'd14;
            else w_blank = 1'b0;
          end
          w_digits[(int'(NF)-1-s)*int'(BW) + (int'(ND)-1-d)*4 +: 4] = w_nib;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_CONV;
      S_CONV:  if (w_last_bit && w_last_fld) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fld     <= '0;
      r_ovf     <= '0;
      r_pm      <= 1'b0;
      r_inv     <= 1'b0;
      r_ap      <= 1'b0;
      r_lz      <= 1'b0;
      r_dab     <= '0;
      r_bit     <= '0;
      r_fidx    <= '0;
      r_work    <= '0;
      digits    <= '1;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_fld  <= w_cap_fld;
            r_ovf  <= w_cap_ovf;
            r_pm   <= w_cap_pm;
            r_inv  <= w_cap_inv;
            r_ap   <= ap_mode;
            r_lz   <= lz_mode;
            r_dab  <= {BW'(0), w_cap_fld[FW-1:0]};
            r_bit  <= '0;
            r_fidx <= '0;
          end
        end
        S_CONV: begin
          r_dab <= w_dab_nxt;
          r_bit <= r_bit + CW'(1);
          if (w_last_bit) begin
            r_work[r_fidx*BW +: BW] <= w_dab_nxt[DW-1 -: BW];
            r_bit <= '0;
            if (!w_last_fld) begin
              r_fidx <= w_fidx_nxt;
              r_dab  <= w_dab_load;
            end
          end
        end
        S_FIX: begin
          digits    <= w_digits;
          ovf       <= w_ovf;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_digit_seq.sv
// Scoreboard bench for time_digit_seq at default parameters (3 fields, 7 bits, 2 digits).
module tb_time_digit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] fields;
  logic        ap_mode;
  logic        lz_mode;
  logic [23:0] digits;
  logic [2:0]  ovf;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] q_d[$];
  logic [2:0]  q_o[$];
  logic [23:0] prev_d;
  logic [2:0]  prev_o;
  bit          seen = 1'b0;

  time_digit_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fields(fields), .ap_mode(ap_mode), .lz_mode(lz_mode),
    .digits(digits), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dg(input logic [3:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  function automatic logic [20:0] fl(input int h, m, s);
    return {7'(h), 7'(m), 7'(s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per presented result
  always @(negedge clk) begin
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      n_vec++;
      if (q_d.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result digits=%h ovf=%b", digits, ovf);
      end else begin
        logic [23:0] ed;
        logic [2:0]  eo;
        ed = q_d.pop_front();
        eo = q_o.pop_front();
        if (digits !== ed || ovf !== eo) begin
          n_err++;
          $display("FAIL result digits=%h ovf=%b expected digits=%h ovf=%b",
                   digits, ovf, ed, eo);
        end
      end
    end
  end

  task automatic send(input string name, input logic [20:0] f, input logic ap,
                      input logic lz, input logic [23:0] ed, input logic [2:0] eo);
    int  n;
    bit  stable;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    fields   = f;
    ap_mode  = ap;
    lz_mode  = lz;
    in_valid = 1'b1;
    q_d.push_back(ed);
    q_o.push_back(eo);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stable = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      if (digits !== prev_d || ovf !== prev_o) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd22);
    chk({name, "_hold_during_conv"}, 32'(stable), 32'd1);
    prev_d = ed;
    prev_o = eo;
    if (out_ready) begin
      n = 0;
      while (out_valid && n < 5) begin
        @(posedge clk); #1;
        n++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    fields    = '0;
    ap_mode   = 1'b0;
    lz_mode   = 1'b0;
    out_ready = 1'b1;
    prev_d    = 24'hFFFFFF;
    prev_o    = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_digits", 32'(digits), 32'hFFFFFF);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    send("h24_basic", fl(13, 5, 9), 1'b0, 1'b0, dg(1, 3, 0, 5, 0, 9), 3'b000);
    send("lz_zero",   fl(0, 7, 45), 1'b0, 1'b1, dg(14, 0, 14, 7, 4, 5), 3'b000);
    send("lz_ten",    fl(10, 0, 0), 1'b0, 1'b1, dg(1, 0, 14, 0, 0, 0), 3'b000);
    send("ap_mid",    fl(0, 30, 59), 1'b1, 1'b0, dg(13, 14, 1, 2, 3, 0), 3'b000);
    send("ap_late",   fl(23, 59, 0), 1'b1, 1'b0, dg(12, 14, 1, 1, 5, 9), 3'b000);
    send("ap_noon",   fl(12, 0, 0), 1'b1, 1'b0, dg(12, 14, 1, 2, 0, 0), 3'b000);
    send("ap_lz",     fl(1, 2, 3), 1'b1, 1'b1, dg(13, 14, 0, 1, 0, 2), 3'b000);
    send("invalid",   fl(127, 5, 100), 1'b0, 1'b0, dg(15, 15, 15, 15, 15, 15), 3'b000);
    send("ovf_min",   fl(5, 100, 3), 1'b0, 1'b0, dg(0, 5, 15, 15, 0, 3), 3'b010);

    // Abort mid-conversion
    fields   = fl(13, 5, 9);
    ap_mode  = 1'b0;
    lz_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_digits", 32'(digits), 32'hFFFFFF);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    prev_d = 24'hFFFFFF;
    prev_o = 3'b000;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    send("after_abort", fl(22, 41, 18), 1'b0, 1'b0, dg(2, 2, 4, 1, 1, 8), 3'b000);

    // Consumer stall with ignored requests
    out_ready = 1'b0;
    send("stall", fl(9, 8, 7), 1'b0, 1'b0, dg(0, 9, 0, 8, 0, 7), 3'b000);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fields   = fl(i + 1, 11, 22);
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      if (digits !== prev_d || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    chk("stall_hold", 32'(ok), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    ok = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || digits !== prev_d) ok = 1'b0;
    end
    chk("no_stray_capture", 32'(ok), 32'd1);

    send("final", fl(7, 59, 58), 1'b0, 1'b1, dg(14, 7, 5, 9, 5, 8), 3'b000);
    chk("queue_drained", 32'(q_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
